pipe_stage_seq: RTL and testbench
=================================

// Module: pipe_stage_seq
// PURPOSE
//  - Parametrised elastic in-order pipeline sequencer.
//  - Carries a DATA_W token through NUM_STAGES register stages, by default FETCH, DECODE, EXECUTE, STORE.
//  - Each stage boundary is a valid/ready handshake. Supports a global stall, a global flush and per-stage occupancy visibility.
//  - Position: sits between the instruction source and the retire/commit logic; drives the stage-status bus for debug and trace.
// PARAMETERS
//  DATA_W      32  width of the token carried through each stage
//  NUM_STAGES  4   number of pipeline stages (>=2); stage 0 = FETCH, stage NUM_STAGES-1 = STORE
//  CNT_W       16  width of the retired-token counter
// PORTS
//  clk           in   1                        rising-edge clock
//  rst_n         in   1                        asynchronous active-low reset
//  in_valid      in   1                        source offers a token
//  in_ready      out  1                        stage 0 can accept this cycle
//  in_data       in   DATA_W                   token payload
//  stall         in   1                        freeze every stage; no movement, no accept, no retire
//  flush         in   1                        discard all in-flight tokens
//  out_valid     out  1                        last stage holds a token
//  out_ready     in   1                        sink accepts the token
//  out_data      out  DATA_W                   payload of the last stage
//  stage_valid   out  NUM_STAGES               bit k = stage k occupied
//  occupancy     out  $clog2(NUM_STAGES+1)     count of occupied stages
//  retired_cnt   out  CNT_W                    tokens retired since reset; wraps modulo 2**CNT_W
// BEHAVIOUR
//  - Reset (async, rst_n=0):
//    - all stage valids = 0, payload regs = 0, retired_cnt = 0.
//    - hence out_valid = 0, occupancy = 0, out_data = 0, stage_valid = 0.
//    - in_ready = 0 while rst_n = 0.
//  - Advance rule, evaluated per stage each cycle (stall = 0, flush = 0):
//    - adv[N-1] = v[N-1] & out_ready.
//    - stage k may load when v[k] = 0 or adv[k] = 1.
//    - adv[k] = v[k] & load_ok[k+1], i.e. ready back-propagates combinationally through full stages.
//    - This gives full throughput: 1 token/cycle with no bubbles under continuous out_ready.
//  - in_ready = rst_n & ~stall & ~flush & (~v[0] | adv[0]).
//  - A token is accepted on in_valid & in_ready.
//  - Latency: a token accepted at edge T is presented at out_valid after edge T+NUM_STAGES-1, i.e. it is visible in stage N-1 NUM_STAGES-1 cycles later.
//  - out_data and stage payloads are held stable while valid and not advancing. No data change under backpressure.
//  - Stall (flush = 0):
//    - all valids and payloads hold.
//    - in_ready = 0 and out_ready is ignored; no retire, retired_cnt holds.
//  - Flush:
//    - on the next edge all v[k] = 0; payload regs need not clear.
//    - in_ready = 0 in the flush cycle, so a coincident in_valid is dropped, not queued.
//    - flush has priority over stall.
//    - A token with out_valid & out_ready in the flush cycle is NOT retired; retired_cnt holds.
//  - retired_cnt increments by 1 on out_valid & out_ready & ~stall & ~flush; it wraps from 2**CNT_W-1 to 0.
//  - occupancy = popcount(stage_valid), registered-consistent: it reflects the current valids, combinational from the v regs.
//  - Simultaneous accept and retire with a full pipe is legal; occupancy stays NUM_STAGES.
//  - Reset mid-operation: all tokens are lost immediately. The first accept after rst_n deasserts behaves as from an empty pipe.
// STRUCTURE
//  - pipe_pkg (shared):
//    - typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, STORE} stage_e.
//    - localparam STAGE_NAMES for trace.
//    - function popcount.
//  - Sub-module pipe_stage_reg: one valid+payload register with load_ok/adv handshake. Instantiated NUM_STAGES times in a generate loop.
//  - Top: ready chain, stall/flush gating, retire counter, occupancy.
// TESTING
//  1. Reset then stream: in_valid=1, tokens 0x1..0x8 on consecutive cycles, out_ready=1.
//     -> out_data 0x1..0x8 on consecutive cycles, first at 3 cycles after the first accept; retired_cnt=8; in_ready never drops.
//  2. Backpressure: fill with 0xA0..0xA3, out_ready=0 for 5 cycles.
//     -> occupancy=4, in_ready=0, out_data stable 0xA0.
//     -> release out_ready: 0xA0..0xA3 in order, no loss or duplication.
//  3. Stall: 2 tokens in flight, stall=1 for 3 cycles with out_ready=1 and in_valid=1.
//     -> stage_valid unchanged, retired_cnt unchanged, no token accepted.
//  4. Flush: pipe full, flush=1 with in_valid=1 (0xFF) and out_ready=1.
//     -> next cycle stage_valid=0, occupancy=0, retired_cnt unchanged, 0xFF never appears at the output.
//  5. Async reset mid-stream: assert rst_n=0 between edges.
//     -> out_valid and stage_valid clear immediately without a clock edge.
//     -> after release, token 0x55 exits after NUM_STAGES-1 cycles.
//  6. Wrap: CNT_W=4, retire 17 tokens -> retired_cnt=1. Repeat tests 1-2 with NUM_STAGES=6, DATA_W=8.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types, trace names and helpers for the pipe_stage_seq sequencer.
package pipe_pkg;

  // Default four-stage naming; deeper pipes reuse the indices numerically.
  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    DECODE  = 2'd1,
    EXECUTE = 2'd2,
    STORE   = 2'd3
  } stage_e;

  // Fixed-width ASCII names (8 chars, space padded) for trace/debug printers.
  localparam int NAME_W = 64;
  localparam logic [NAME_W-1:0] STAGE_NAMES [4] = '{
    "FETCH   ",
    "DECODE  ",
    "EXECUTE ",
    "STORE   "
  };

  // Widest stage_valid vector the popcount helper handles.
  localparam int MAX_STAGES = 32;

  // Number of set bits; callers zero-extend their valid vector to MAX_STAGES.
  function automatic int unsigned popcount(input logic [MAX_STAGES-1:0] bits);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_STAGES; i++) begin
      n += 32'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline slot: a valid bit plus payload, loaded through the load_ok/adv handshake.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              load_ok,
  input  logic              up_valid,
  input  logic [DATA_W-1:0] up_data,
  output logic              valid,
  output logic [DATA_W-1:0] data
);

  logic              valid_q;
  logic              valid_d;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] data_d;

  // Next-state: clear on flush, otherwise take the upstream token whenever the slot may load.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clr) begin
      valid_d = 1'b0;
    end else if (load_ok) begin
      valid_d = up_valid;
      if (up_valid) begin
        data_d = up_data;
      end
    end
  end

  // Slot registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

// File: rtl/pipe_stage_seq.sv
// Elastic in-order pipeline sequencer: ready chain, stall/flush gating, retire counter, occupancy.
module pipe_stage_seq
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_STAGES = 4,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              stall,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [DATA_W-1:0]                 out_data,
  output logic [NUM_STAGES-1:0]             stage_valid,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]                  retired_cnt
);

  localparam int OCC_W = $clog2(NUM_STAGES+1);

  logic                  go;
  logic                  chain_ok;
  logic                  accept;
  logic [NUM_STAGES-1:0] stage_v;
  logic [NUM_STAGES-1:0] load_ok;
  logic [NUM_STAGES-1:0] adv;
  logic [NUM_STAGES-1:0] up_valid;
  logic [DATA_W-1:0]     stage_data [NUM_STAGES];
  logic [CNT_W-1:0]      retired_q;
  logic [CNT_W-1:0]      retired_d;

  // Ready back-propagation from the sink to stage 0; stall or flush freezes every advance.
  always_comb begin
    go       = ~stall & ~flush;
    adv      = '0;
    load_ok  = '0;
    chain_ok = go & out_ready;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      adv[k]     = stage_v[k] & chain_ok;
      load_ok[k] = ~stage_v[k] | adv[k];
      chain_ok   = go & load_ok[k];
    end
  end

  assign in_ready = rst_n & go & load_ok[0];
  assign accept   = in_valid & in_ready;

  // Token offered to each slot: the source for stage 0, the advancing neighbour otherwise.
  always_comb begin
    up_valid    = '0;
    up_valid[0] = accept;
    for (int k = 1; k < NUM_STAGES; k++) begin
      up_valid[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .load_ok  (load_ok[k]),
        .up_valid (up_valid[k]),
        .up_data  (in_data),
        .valid    (stage_v[k]),
        .data     (stage_data[k])
      );
    end else begin : g_body
      pipe_stage_reg #(.DATA_W(DATA_W)) u_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .load_ok  (load_ok[k]),
        .up_valid (up_valid[k]),
        .up_data  (stage_data[k-1]),
        .valid    (stage_v[k]),
        .data     (stage_data[k])
      );
    end
  end

  // Retire count: the last stage advancing already excludes stall and flush cycles.
  always_comb begin
    retired_d = retired_q + CNT_W'(adv[NUM_STAGES-1]);
  end

  // Retired-token counter, wraps naturally at 2**CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_q <= '0;
    end else begin
      retired_q <= retired_d;
    end
  end

  assign out_valid   = stage_v[NUM_STAGES-1];
  assign out_data    = stage_data[NUM_STAGES-1];
  assign stage_valid = stage_v;
  assign occupancy   = OCC_W'(popcount(MAX_STAGES'(stage_v)));
  assign retired_cnt = retired_q;

endmodule

// File: tb/tb_pipe_stage_seq.sv
// Bench for pipe_stage_seq: a default 4-stage instance and a 6-stage/8-bit/4-bit-counter
// instance share one stimulus stream and are each compared with a token-position model.
module tb_pipe_stage_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        stall;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid;
  logic [31:0] a_out_data;
  logic [3:0]  a_stage_valid;
  logic [2:0]  a_occupancy;
  logic [15:0] a_retired_cnt;

  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_data;
  logic [5:0]  b_stage_valid;
  logic [2:0]  b_occupancy;
  logic [3:0]  b_retired_cnt;

  int checks = 0;
  int errors = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  pipe_stage_seq dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .stall(stall), .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .stage_valid(a_stage_valid), .occupancy(a_occupancy),
    .retired_cnt(a_retired_cnt)
  );

  pipe_stage_seq #(.DATA_W(8), .NUM_STAGES(6), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data[7:0]),
    .stall(stall), .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .stage_valid(b_stage_valid), .occupancy(b_occupancy),
    .retired_cnt(b_retired_cnt)
  );

  // Model: per instance, in-flight tokens oldest first, each with its stage position.
  int          nst  [2] = '{4, 6};
  logic [31:0] dmask[2] = '{32'hFFFF_FFFF, 32'h0000_00FF};
  int          cmod [2] = '{65536, 16};
  int          tcnt [2];
  int          tpos [2][8];
  logic [31:0] tdat [2][8];
  int          rcnt [2];

  function automatic logic obs_in_ready(int m);  return (m == 0) ? a_in_ready : b_in_ready; endfunction
  function automatic logic obs_out_valid(int m); return (m == 0) ? a_out_valid : b_out_valid; endfunction
  function automatic logic [31:0] obs_out_data(int m);
    return (m == 0) ? a_out_data : 32'(b_out_data);
  endfunction
  function automatic logic [31:0] obs_stage_valid(int m);
    return (m == 0) ? 32'(a_stage_valid) : 32'(b_stage_valid);
  endfunction
  function automatic int obs_occ(int m); return (m == 0) ? int'(a_occupancy) : int'(b_occupancy); endfunction
  function automatic int obs_cnt(int m); return (m == 0) ? int'(a_retired_cnt) : int'(b_retired_cnt); endfunction

  // Furthest-back free position after this cycle's moves; >= 0 means stage 0 can take a token.
  function automatic int last_limit(int m);
    int lim, np;
    lim = out_ready ? nst[m] : nst[m] - 1;
    for (int i = 0; i < tcnt[m]; i++) begin
      np  = (tpos[m][i] + 1 > lim) ? lim : tpos[m][i] + 1;
      lim = np - 1;
    end
    return lim;
  endfunction

  function automatic logic exp_in_ready(int m);
    return rst_n && !stall && !flush && (last_limit(m) >= 0);
  endfunction
  function automatic logic exp_out_valid(int m);
    return (tcnt[m] > 0) && (tpos[m][0] == nst[m] - 1);
  endfunction
  function automatic logic [31:0] exp_stage_valid(int m);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < tcnt[m]; i++) v |= 32'(1) << tpos[m][i];
    return v;
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      tcnt[m] = 0;
      rcnt[m] = 0;
    end
  endfunction

  // Apply one clock edge to the model using the inputs currently driven.
  function automatic void model_step(int m);
    int lim, np, k;
    int npos[8];
    logic [31:0] ndat[8];
    if (!rst_n) begin
      tcnt[m] = 0;
      rcnt[m] = 0;
      return;
    end
    if (flush) begin
      tcnt[m] = 0;
      return;
    end
    if (stall) return;
    lim = out_ready ? nst[m] : nst[m] - 1;
    k = 0;
    for (int i = 0; i < tcnt[m]; i++) begin
      np  = (tpos[m][i] + 1 > lim) ? lim : tpos[m][i] + 1;
      lim = np - 1;
      if (np == nst[m]) begin
        rcnt[m] = (rcnt[m] + 1) % cmod[m];
      end else begin
        npos[k] = np;
        ndat[k] = tdat[m][i];
        k++;
      end
    end
    if (in_valid && lim >= 0) begin
      npos[k] = 0;
      ndat[k] = in_data & dmask[m];
      k++;
    end
    for (int i = 0; i < k; i++) begin
      tpos[m][i] = npos[i];
      tdat[m][i] = ndat[i];
    end
    tcnt[m] = k;
  endfunction

  task automatic step();
    for (int m = 0; m < 2; m++) model_step(m);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    in_valid  = 1'b0;
    in_data   = '0;
    stall     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    set_idle();
    in_valid = 1'b1;
    rst_n    = 1'b0;
    model_reset();
    step();
    step();
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_in_ready(m) !== 1'b0) begin errors++; $display("[TB] FAIL reset_in_ready dut=%0d got=%0h exp=0", m, obs_in_ready(m)); end
      checks++; if (obs_out_valid(m) !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid dut=%0d got=%0h exp=0", m, obs_out_valid(m)); end
      checks++; if (obs_out_data(m) !== 32'h0) begin errors++; $display("[TB] FAIL reset_out_data dut=%0d got=%0h exp=0", m, obs_out_data(m)); end
      checks++; if (obs_stage_valid(m) !== 32'h0) begin errors++; $display("[TB] FAIL reset_stage_valid dut=%0d got=%0h exp=0", m, obs_stage_valid(m)); end
      checks++; if (obs_occ(m) !== 0) begin errors++; $display("[TB] FAIL reset_occupancy dut=%0d got=%0d exp=0", m, obs_occ(m)); end
      checks++; if (obs_cnt(m) !== 0) begin errors++; $display("[TB] FAIL reset_retired dut=%0d got=%0d exp=0", m, obs_cnt(m)); end
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int nxt[2] = '{1, 1};
    int lat[2] = '{-1, -1};
    for (int i = 0; i < 20; i++) begin
      in_valid  = (i < 8);
      in_data   = 32'(i + 1);
      out_ready = 1'b1;
      #1;
      for (int m = 0; m < 2; m++) begin
        if (i < 8) begin
          checks++; if (obs_in_ready(m) !== 1'b1) begin errors++; $display("[TB] FAIL stream_in_ready dut=%0d cyc=%0d got=%0h exp=1", m, i, obs_in_ready(m)); end
        end
        checks++; if (obs_out_valid(m) !== exp_out_valid(m)) begin errors++; $display("[TB] FAIL stream_out_valid dut=%0d cyc=%0d got=%0h exp=%0h", m, i, obs_out_valid(m), exp_out_valid(m)); end
        if (obs_out_valid(m) === 1'b1) begin
          if (lat[m] < 0) lat[m] = i - 1;
          checks++; if (obs_out_data(m) !== 32'(nxt[m])) begin errors++; $display("[TB] FAIL stream_order dut=%0d got=%0h exp=%0h", m, obs_out_data(m), nxt[m]); end
          nxt[m]++;
        end
      end
      step();
    end
    in_valid = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++; if (lat[m] !== nst[m] - 1) begin errors++; $display("[TB] FAIL stream_latency dut=%0d got=%0d exp=%0d", m, lat[m], nst[m] - 1); end
      checks++; if (nxt[m] !== 9) begin errors++; $display("[TB] FAIL stream_count dut=%0d got=%0d exp=9", m, nxt[m] - 1); end
      checks++; if (obs_cnt(m) !== 8) begin errors++; $display("[TB] FAIL stream_retired dut=%0d got=%0d exp=8", m, obs_cnt(m)); end
    end
  endtask

  task automatic test_backpressure();
    int seen[2] = '{0, 0};
    set_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(i);
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_in_ready(m) !== 1'b1) begin errors++; $display("[TB] FAIL bp_fill_ready dut=%0d got=%0h exp=1", m, obs_in_ready(m)); end
      end
      step();
    end
    in_valid = 1'b0;
    repeat (5) begin
      #1;
      checks++; if (a_occupancy !== 3'd4) begin errors++; $display("[TB] FAIL bp_occupancy dut=0 got=%0d exp=4", a_occupancy); end
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready dut=0 got=%0h exp=0", a_in_ready); end
      checks++; if (a_out_data !== 32'hA0 || a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold dut=0 got=%0h/%0h exp=a0/1", a_out_data, a_out_valid); end
      checks++; if (obs_stage_valid(1) !== exp_stage_valid(1)) begin errors++; $display("[TB] FAIL bp_stage_valid dut=1 got=%0h exp=%0h", obs_stage_valid(1), exp_stage_valid(1)); end
      checks++; if (b_occupancy !== 3'd4) begin errors++; $display("[TB] FAIL bp_occupancy dut=1 got=%0d exp=4", b_occupancy); end
      step();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_out_valid(m) !== exp_out_valid(m)) begin errors++; $display("[TB] FAIL bp_out_valid dut=%0d got=%0h exp=%0h", m, obs_out_valid(m), exp_out_valid(m)); end
        if (obs_out_valid(m) === 1'b1) begin
          checks++; if (obs_out_data(m) !== 32'hA0 + 32'(seen[m])) begin errors++; $display("[TB] FAIL bp_order dut=%0d got=%0h exp=%0h", m, obs_out_data(m), 32'hA0 + 32'(seen[m])); end
          seen[m]++;
        end
      end
      step();
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (seen[m] !== 4) begin errors++; $display("[TB] FAIL bp_count dut=%0d got=%0d exp=4", m, seen[m]); end
    end
  endtask

  task automatic test_stall();
    int cap[2];
    set_idle();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h30 + 32'(i);
      step();
    end
    cap[0] = rcnt[0];
    cap[1] = rcnt[1];
    stall    = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h77;
    repeat (3) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_stage_valid(m) !== 32'h3) begin errors++; $display("[TB] FAIL stall_stage_valid dut=%0d got=%0h exp=3", m, obs_stage_valid(m)); end
        checks++; if (obs_in_ready(m) !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready dut=%0d got=%0h exp=0", m, obs_in_ready(m)); end
        checks++; if (obs_cnt(m) !== cap[m]) begin errors++; $display("[TB] FAIL stall_retired dut=%0d got=%0d exp=%0d", m, obs_cnt(m), cap[m]); end
      end
      step();
    end
    stall    = 1'b0;
    in_valid = 1'b0;
    repeat (8) begin
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_out_valid(m) !== exp_out_valid(m) || (exp_out_valid(m) && obs_out_data(m) !== tdat[m][0])) begin errors++; $display("[TB] FAIL stall_drain dut=%0d got=%0h/%0h exp=%0h", m, obs_out_valid(m), obs_out_data(m), exp_out_valid(m)); end
      end
      step();
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_cnt(m) !== (cap[m] + 2) % cmod[m]) begin errors++; $display("[TB] FAIL stall_total dut=%0d got=%0d exp=%0d", m, obs_cnt(m), (cap[m] + 2) % cmod[m]); end
    end
  endtask

  task automatic test_flush();
    int cap[2];
    set_idle();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h40 + 32'(i);
      step();
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hFF;
    out_ready = 1'b1;
    cap[0] = rcnt[0];
    cap[1] = rcnt[1];
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_in_ready(m) !== 1'b0) begin errors++; $display("[TB] FAIL flush_in_ready dut=%0d got=%0h exp=0", m, obs_in_ready(m)); end
    end
    checks++; if (a_stage_valid !== 4'hF) begin errors++; $display("[TB] FAIL flush_full dut=0 got=%0h exp=f", a_stage_valid); end
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_stage_valid(m) !== 32'h0) begin errors++; $display("[TB] FAIL flush_stage_valid dut=%0d got=%0h exp=0", m, obs_stage_valid(m)); end
      checks++; if (obs_occ(m) !== 0) begin errors++; $display("[TB] FAIL flush_occupancy dut=%0d got=%0d exp=0", m, obs_occ(m)); end
      checks++; if (obs_cnt(m) !== cap[m]) begin errors++; $display("[TB] FAIL flush_retired dut=%0d got=%0d exp=%0d", m, obs_cnt(m), cap[m]); end
    end
    repeat (8) begin
      step();
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_out_valid(m) !== 1'b0) begin errors++; $display("[TB] FAIL flush_leak dut=%0d got=%0h/%0h exp=0", m, obs_out_valid(m), obs_out_data(m)); end
      end
    end
  endtask

  task automatic test_async_reset();
    int lat[2] = '{-1, -1};
    set_idle();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      step();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_stage_valid(m) !== 32'h0 || obs_out_valid(m) !== 1'b0) begin errors++; $display("[TB] FAIL async_clear dut=%0d got=%0h/%0h exp=0/0", m, obs_stage_valid(m), obs_out_valid(m)); end
      checks++; if (obs_in_ready(m) !== 1'b0) begin errors++; $display("[TB] FAIL async_in_ready dut=%0d got=%0h exp=0", m, obs_in_ready(m)); end
    end
    step();
    #3 rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'h55;
    #1;
    for (int m = 0; m < 2; m++) begin
      checks++; if (obs_in_ready(m) !== 1'b1) begin errors++; $display("[TB] FAIL async_restart_ready dut=%0d got=%0h exp=1", m, obs_in_ready(m)); end
    end
    step();
    in_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      for (int m = 0; m < 2; m++) begin
        if (obs_out_valid(m) === 1'b1 && lat[m] < 0) begin
          lat[m] = c;
          checks++; if (obs_out_data(m) !== 32'h55) begin errors++; $display("[TB] FAIL async_data dut=%0d got=%0h exp=55", m, obs_out_data(m)); end
        end
      end
      step();
    end
    for (int m = 0; m < 2; m++) begin
      checks++; if (lat[m] !== nst[m] - 1) begin errors++; $display("[TB] FAIL async_latency dut=%0d got=%0d exp=%0d", m, lat[m], nst[m] - 1); end
    end
  endtask

  task automatic test_wrap();
    set_idle();
    rst_n = 1'b0;
    model_reset();
    step();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      in_valid = (i < 17);
      in_data  = 32'(i);
      #1;
      step();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (a_retired_cnt !== 16'd17) begin errors++; $display("[TB] FAIL wrap_retired dut=0 got=%0d exp=17", a_retired_cnt); end
    checks++; if (b_retired_cnt !== 4'd1) begin errors++; $display("[TB] FAIL wrap_retired dut=1 got=%0d exp=1", b_retired_cnt); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 29) == 0);
      #1;
      for (int m = 0; m < 2; m++) begin
        checks++; if (obs_in_ready(m) !== exp_in_ready(m)) begin errors++; $display("[TB] FAIL rand_in_ready dut=%0d cyc=%0d got=%0h exp=%0h", m, i, obs_in_ready(m), exp_in_ready(m)); end
        checks++; if (obs_out_valid(m) !== exp_out_valid(m)) begin errors++; $display("[TB] FAIL rand_out_valid dut=%0d cyc=%0d got=%0h exp=%0h", m, i, obs_out_valid(m), exp_out_valid(m)); end
        if (exp_out_valid(m)) begin
          checks++; if (obs_out_data(m) !== tdat[m][0]) begin errors++; $display("[TB] FAIL rand_out_data dut=%0d cyc=%0d got=%0h exp=%0h", m, i, obs_out_data(m), tdat[m][0]); end
        end
        checks++; if (obs_stage_valid(m) !== exp_stage_valid(m)) begin errors++; $display("[TB] FAIL rand_stage_valid dut=%0d cyc=%0d got=%0h exp=%0h", m, i, obs_stage_valid(m), exp_stage_valid(m)); end
        checks++; if (obs_occ(m) !== tcnt[m]) begin errors++; $display("[TB] FAIL rand_occupancy dut=%0d cyc=%0d got=%0d exp=%0d", m, i, obs_occ(m), tcnt[m]); end
        checks++; if (obs_cnt(m) !== rcnt[m]) begin errors++; $display("[TB] FAIL rand_retired dut=%0d cyc=%0d got=%0d exp=%0d", m, i, obs_cnt(m), rcnt[m]); end
      end
      step();
    end
    set_idle();
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_stall();
    test_flush();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
